// File: rtl/regfile_writer.sv
// Write-back arbiter and in-order buffer owning the register file write port.
// Two producers (ALU, load/multi-cycle) feed a small FIFO; pending writes are queryable for forwarding.
module regfile_writer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     A_Valid,
  input  logic [4:0]               A_Addr,
  input  logic [31:0]              A_Data,
  output logic                     A_Ready,
  input  logic                     B_Valid,
  input  logic [4:0]               B_Addr,
  input  logic [31:0]              B_Data,
  output logic                     B_Ready,
  input  logic                     Hold,
  output logic [4:0]               W_Addr,
  output logic [31:0]              W_Data,
  output logic                     WE,
  input  logic [4:0]               Q_Addr,
  output logic                     Q_Hit,
  output logic [31:0]              Q_Data,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_last_grant;

  logic          w_full;
  logic          w_grant_a;
  logic          w_grant_b;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_push_addr;
  logic [DW-1:0] w_push_data;
  logic [CW-1:0] w_count_nxt;
  logic          w_q_hit;
  logic [DW-1:0] w_q_data;
  logic [PW-1:0] w_idx;

  // Round-robin on ties: the source not named by last_grant wins.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_grant_a = A_Valid && !w_full && (!B_Valid || r_last_grant);
  assign w_grant_b = B_Valid && !w_full && (!A_Valid || !r_last_grant);

  // Register 0 results are handshaken but never stored.
  assign w_push_addr = w_grant_a ? A_Addr : B_Addr;
  assign w_push_data = w_grant_a ? A_Data : B_Data;
  assign w_push      = (w_grant_a || w_grant_b) && (w_push_addr != '0);
  assign w_pop       = (r_count != '0) && !Hold;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= w_push_addr;
        r_data[r_tail] <= w_push_data;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= w_count_nxt;
      if (w_grant_a || w_grant_b) begin
        r_last_grant <= w_grant_b;
      end
    end
  end

  // Walk from oldest to youngest so the last match is the youngest pending write.
  always_comb begin
    w_q_hit  = 1'b0;
    w_q_data = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == Q_Addr) && (Q_Addr != '0)) begin
        w_q_hit  = 1'b1;
        w_q_data = r_data[w_idx];
      end
    end
  end

  assign A_Ready = w_grant_a;
  assign B_Ready = w_grant_b;
  assign WE      = w_pop;
  assign W_Addr  = w_pop ? r_addr[r_head] : '0;
  assign W_Data  = w_pop ? r_data[r_head] : '0;
  assign Q_Hit   = w_q_hit;
  assign Q_Data  = w_q_data;
  assign Count   = r_count;

endmodule
